moving_average: RTL

//   Boxcar (moving-average) anti-alias filter placed directly upstream of the decimator.

---
 rtl/moving_average_pkg.sv | 23 ++
 rtl/moving_average_sample_ram.sv | 34 +++
 rtl/moving_average.sv | 104 ++++++++++
 3 files changed

// File: rtl/moving_average_pkg.sv
// Shared definitions for the moving-average filter slice.
//   ARCH_BEHAVIORAL    : the only implementation select string
//   DEFAULT_DATA_WIDTH : default sample width
//   clog2()            : ceiling log2, usable in parameter expressions
package moving_average_pkg;

  localparam string ARCH_BEHAVIORAL    = "BEHAVIORAL";
  localparam int    DEFAULT_DATA_WIDTH = 8;

  // Ceiling log2; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/moving_average_sample_ram.sv
// sample_ram: window storage for the moving-average filter.
// Ports:
//   clk   in  1      write clock
//   we    in  1      write enable
//   addr  in  ADDR_W shared read/write address
//   wdata in  WIDTH  write data
//   rdata out WIDTH  combinational read of mem[addr] (old contents on a write cycle)
// Storage is deliberately not reset; the parent gates reads with its fill count.
module sample_ram
  import moving_average_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            we,
  input  logic [((DEPTH > 1) ? clog2(DEPTH) : 1)-1:0]     addr,
  input  logic [WIDTH-1:0]                                wdata,
  output logic [WIDTH-1:0]                                rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write of the newest sample.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read-before-write: the value returned is what gets overwritten this edge.
  assign rdata = mem[addr];

endmodule

// File: rtl/moving_average.sv
// moving_average: boxcar filter over the last 2**LOG2_TAPS accepted samples.
// Ports:
//   clk           in  1          single clock, posedge
//   rst           in  1          asynchronous active-high reset
//   en            in  1          global enable; low freezes all state
//   data_valid_in in  1          data_in carries a new sample
//   data_in       in  DATA_WIDTH unsigned input sample
//   data_valid    out 1          one-cycle strobe for a new average
//   data_out      out DATA_WIDTH floor(sum of last N samples / N), registered
module moving_average
  import moving_average_pkg::*;
#(
  parameter string ARCHITECTURE = ARCH_BEHAVIORAL,
  parameter int    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int    LOG2_TAPS    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  data_valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int SUM_W = DATA_WIDTH + LOG2_TAPS;

  localparam logic [LOG2_TAPS:0]   FILL_FULL = (LOG2_TAPS + 1)'(TAPS);
  localparam logic [LOG2_TAPS:0]   FILL_LAST = (LOG2_TAPS + 1)'(TAPS - 1);
  localparam logic [LOG2_TAPS:0]   FILL_ONE  = (LOG2_TAPS + 1)'(1);
  localparam logic [LOG2_TAPS-1:0] WPTR_ONE  = LOG2_TAPS'(1);

  if (ARCHITECTURE != ARCH_BEHAVIORAL) begin : g_bad_arch
    $error("moving_average: unsupported ARCHITECTURE");
  end

  logic [LOG2_TAPS-1:0]  wptr;
  logic [LOG2_TAPS:0]    fill;
  logic [SUM_W-1:0]      sum;

  logic                  accept;
  logic                  full;
  logic                  strobe;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] oldest;
  logic [SUM_W-1:0]      sum_next;
  logic [LOG2_TAPS:0]    fill_next;

  assign accept = en & data_valid_in;
  assign full   = (fill == FILL_FULL);

  sample_ram #(
    .DEPTH (TAPS),
    .WIDTH (DATA_WIDTH)
  ) u_sample_ram (
    .clk   (clk),
    .we    (accept),
    .addr  (wptr),
    .wdata (data_in),
    .rdata (ram_rdata)
  );

  // Next-state arithmetic; stale RAM contents are ignored until the window is full.
  always_comb begin
    oldest    = '0;
    fill_next = fill;
    if (full) begin
      oldest    = ram_rdata;
      fill_next = fill;
    end else begin
      oldest    = '0;
      fill_next = fill + FILL_ONE;
    end
    // Net change is add-then-subtract of an in-window value, so sum never goes negative.
    sum_next = sum + {{LOG2_TAPS{1'b0}}, data_in} - {{LOG2_TAPS{1'b0}}, oldest};
    // The accept that completes the window (or any later one) yields a strobe.
    strobe   = full || (fill == FILL_LAST);
  end

  // Pointer, fill count, running sum and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      fill       <= '0;
      sum        <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else if (accept) begin
      wptr       <= wptr + WPTR_ONE;
      fill       <= fill_next;
      sum        <= sum_next;
      data_valid <= strobe;
      if (strobe) begin
        data_out <= sum_next[SUM_W-1:LOG2_TAPS];
      end else begin
        data_out <= data_out;
      end
    end else begin
      data_valid <= 1'b0;
    end
  end

endmodule
